// File: rtl/hop_kernel_seq.sv
// Sequential hop-selection kernel: basic hop via permutation plus iterative mod, then AFH remap by live map scan.
// Latency 4+n79 cycles when the basic channel is used, 6+n79+nN+p when remapped; start is ignored while busy.
module hop_kernel_seq #(
  parameter int NUM_CH = 79,
  parameter int CH_W   = 7
) (
  input  logic              divffclk,
  input  logic              rstz,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        X,
  input  logic [4:0]        A,
  input  logic [4:0]        C,
  input  logic [3:0]        B,
  input  logic [8:0]        D,
  input  logic [6:0]        E,
  input  logic [6:0]        F,
  input  logic [6:0]        Fprime,
  input  logic              Y1,
  input  logic [5:0]        Y2,
  input  logic [NUM_CH-1:0] afh_map,
  input  logic [6:0]        afh_modN,
  output logic              busy,
  output logic              done,
  output logic [CH_W-1:0]   fk,
  output logic              remapped,
  output logic              err
);

  localparam int SW = 9;
  localparam logic [SW-1:0]   N79      = SW'(NUM_CH);
  localparam logic [CH_W-1:0] HALF_C   = CH_W'((NUM_CH + 1) / 2);
  localparam logic [CH_W-1:0] LAST_POS = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PERM, S_MOD79, S_CHK, S_MODN, S_SCAN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [4:0]        x_q, a_q, c_q;
  logic [3:0]        b_q;
  logic [8:0]        d_q;
  logic [6:0]        e_q, f_q, fp_q, modn_q;
  logic              y1_q;
  logic [5:0]        y2_q;
  logic [NUM_CH-1:0] map_q;

  logic [SW-1:0]     s79, sn;
  logic [CH_W-1:0]   pos, cnt;

  logic [4:0]        z, zp;
  logic [SW-1:0]     sum79, sumn, nq;
  logic [CH_W-1:0]   ch_chk, ch_scan;
  logic              used_chk, used_scan, hit;

  logic              res_set, res_rm, res_err;
  logic [CH_W-1:0]   res_fk;

  function automatic logic [4:0] bfly(input logic [4:0] v, input logic en,
                                      input logic [2:0] i, input logic [2:0] j);
    logic [4:0] r;
    r = v;
    if (en) begin
      r[i] = v[j];
      r[j] = v[i];
    end
    return r;
  endfunction

  // Seven butterfly stages, P13/P12 first through P1/P0 last.
  function automatic logic [4:0] perm5(input logic [4:0] zin, input logic [13:0] p);
    logic [4:0] v;
    v = zin;
    v = bfly(v, p[13], 3'd1, 3'd2);
    v = bfly(v, p[12], 3'd0, 3'd3);
    v = bfly(v, p[11], 3'd1, 3'd3);
    v = bfly(v, p[10], 3'd2, 3'd4);
    v = bfly(v, p[9],  3'd0, 3'd3);
    v = bfly(v, p[8],  3'd1, 3'd4);
    v = bfly(v, p[7],  3'd3, 3'd4);
    v = bfly(v, p[6],  3'd0, 3'd2);
    v = bfly(v, p[5],  3'd1, 3'd3);
    v = bfly(v, p[4],  3'd0, 3'd4);
    v = bfly(v, p[3],  3'd3, 3'd4);
    v = bfly(v, p[2],  3'd1, 3'd2);
    v = bfly(v, p[1],  3'd2, 3'd3);
    v = bfly(v, p[0],  3'd0, 3'd1);
    return v;
  endfunction

  // Even channels first, then odd: index i -> RF channel.
  function automatic logic [CH_W-1:0] bmap(input logic [CH_W-1:0] i);
    logic [CH_W-1:0] dlt;
    if (i < HALF_C) begin
      return {i[CH_W-2:0], 1'b0};
    end
    dlt = i - HALF_C;
    return {dlt[CH_W-2:0], 1'b1};
  endfunction

  always_comb begin
    z         = (x_q + a_q) ^ {1'b0, b_q};
    zp        = perm5(z, {c_q ^ {5{y1_q}}, d_q});
    sum79     = SW'(e_q) + SW'(f_q)  + SW'(zp) + SW'(y2_q);
    sumn      = SW'(e_q) + SW'(fp_q) + SW'(zp) + SW'(y2_q);
    nq        = SW'(modn_q);
    ch_chk    = bmap(s79[CH_W-1:0]);
    used_chk  = map_q[ch_chk];
    ch_scan   = bmap(pos);
    used_scan = map_q[ch_scan];
    hit       = used_scan && (SW'(cnt) == sn);
  end

  always_comb begin
    state_nxt = state;
    res_set   = 1'b0;
    res_fk    = '0;
    res_rm    = 1'b0;
    res_err   = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PERM;
      S_PERM:  state_nxt = S_MOD79;
      S_MOD79: if (s79 < N79) state_nxt = S_CHK;
      S_CHK: begin
        if (used_chk) begin
          state_nxt = S_DONE;
          res_set   = 1'b1;
          res_fk    = ch_chk;
        end else begin
          state_nxt = S_MODN;
        end
      end
      S_MODN: begin
        if (modn_q == '0) begin
          state_nxt = S_DONE;
          res_set   = 1'b1;
          res_err   = 1'b1;
        end else if (sn < nq) begin
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit) begin
          state_nxt = S_DONE;
          res_set   = 1'b1;
          res_fk    = ch_scan;
          res_rm    = 1'b1;
        end else if (pos == LAST_POS) begin
          state_nxt = S_DONE;
          res_set   = 1'b1;
          res_err   = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      res_set   = 1'b0;
    end
  end

  always_ff @(posedge divffclk or negedge rstz) begin
    if (!rstz) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge divffclk or negedge rstz) begin
    if (!rstz) begin
      x_q    <= '0;
      a_q    <= '0;
      c_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      e_q    <= '0;
      f_q    <= '0;
      fp_q   <= '0;
      y1_q   <= 1'b0;
      y2_q   <= '0;
      map_q  <= '0;
      modn_q <= '0;
      s79    <= '0;
      sn     <= '0;
      pos    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q    <= X;
            a_q    <= A;
            c_q    <= C;
            b_q    <= B;
            d_q    <= D;
            e_q    <= E;
            f_q    <= F;
            fp_q   <= Fprime;
            y1_q   <= Y1;
            y2_q   <= Y2;
            map_q  <= afh_map;
            modn_q <= afh_modN;
          end
        end
        S_PERM: begin
          s79 <= sum79;
          sn  <= sumn;
        end
        S_MOD79: if (s79 >= N79) s79 <= s79 - N79;
        S_CHK: begin
          pos <= '0;
          cnt <= '0;
        end
        S_MODN: if (modn_q != '0 && sn >= nq) sn <= sn - nq;
        S_SCAN: begin
          pos <= pos + CH_W'(1);
          if (used_scan) cnt <= cnt + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Results only move on a completed request; abort leaves the previous ones visible.
  always_ff @(posedge divffclk or negedge rstz) begin
    if (!rstz) begin
      fk       <= '0;
      remapped <= 1'b0;
      err      <= 1'b0;
    end else if (res_set) begin
      fk       <= res_fk;
      remapped <= res_rm;
      err      <= res_err;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_hop_kernel_seq.sv
// Bench for hop_kernel_seq: directed cases, abort/reset/busy-start, and random vectors against a reference model.
module tb_hop_kernel_seq;

  localparam int NCH  = 79;
  localparam int HALF = (NCH + 1) / 2;
  // Butterfly pair swapped by control bit Pi.
  localparam int PA [14] = '{0, 2, 1, 3, 0, 1, 0, 3, 1, 0, 2, 1, 0, 1};
  localparam int PB [14] = '{1, 3, 2, 4, 4, 3, 2, 4, 4, 3, 4, 3, 3, 2};

  logic           divffclk = 1'b0;
  logic           rstz, start, abort;
  logic [4:0]     X, A, C;
  logic [3:0]     B;
  logic [8:0]     D;
  logic [6:0]     E, F, Fprime;
  logic           Y1;
  logic [5:0]     Y2;
  logic [NCH-1:0] afh_map;
  logic [6:0]     afh_modN;
  logic           busy, done;
  logic [6:0]     fk;
  logic           remapped, err;

  int n_chk  = 0;
  int n_fail = 0;

  hop_kernel_seq #(.NUM_CH(NCH), .CH_W(7)) dut (
    .divffclk(divffclk), .rstz(rstz), .start(start), .abort(abort),
    .X(X), .A(A), .C(C), .B(B), .D(D), .E(E), .F(F), .Fprime(Fprime),
    .Y1(Y1), .Y2(Y2), .afh_map(afh_map), .afh_modN(afh_modN),
    .busy(busy), .done(done), .fk(fk), .remapped(remapped), .err(err)
  );

  always #5 divffclk = ~divffclk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bmap_m(input int i);
    return (i < HALF) ? 2 * i : 2 * (i - HALF) + 1;
  endfunction

  task automatic model(output int lat, output int efk, output int erm, output int eerr);
    int z [5];
    int zv, p14, zp, s79, sn, n79, ch, kp, nn, t, nmod;
    int used_pos [$];
    zv  = ((int'(X) + int'(A)) % 32) ^ int'(B);
    p14 = (int'(C ^ {5{Y1}}) << 9) | int'(D);
    for (int i = 0; i < 5; i++) z[i] = (zv >> i) & 1;
    for (int i = 13; i >= 0; i--) begin
      if (((p14 >> i) & 1) == 1) begin
        t = z[PA[i]];
        z[PA[i]] = z[PB[i]];
        z[PB[i]] = t;
      end
    end
    zp = 0;
    for (int i = 0; i < 5; i++) zp += z[i] << i;
    s79  = int'(E) + int'(F) + zp + int'(Y2);
    n79  = s79 / NCH;
    ch   = bmap_m(s79 % NCH);
    nmod = int'(afh_modN);
    efk = 0; erm = 0; eerr = 0;
    if (afh_map[7'(ch)]) begin
      efk = ch;
      lat = 4 + n79;
    end else if (nmod == 0) begin
      eerr = 1;
      lat  = 5 + n79;
    end else begin
      sn = int'(E) + int'(Fprime) + zp + int'(Y2);
      kp = sn % nmod;
      nn = sn / nmod;
      for (int p = 0; p < NCH; p++)
        if (afh_map[7'(bmap_m(p))]) used_pos.push_back(p);
      if (kp < used_pos.size()) begin
        efk = bmap_m(used_pos[kp]);
        erm = 1;
        lat = 6 + n79 + nn + used_pos[kp];
      end else begin
        eerr = 1;
        lat  = 6 + n79 + nn + NCH - 1;
      end
    end
  endtask

  // Entered just after a rising edge with the DUT idle; poke_cyc>0 re-pulses start mid-request.
  task automatic run_req(input string tag, input int exp_lat, input int exp_fk,
                         input int exp_rm, input int exp_err, input int poke_cyc);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    start = 1'b1;
    while (!got && cyc < 600) begin
      @(negedge divffclk);
      check({tag, "_busy"}, int'(busy), int'(cyc != 0));
      if (done) begin
        got = 1'b1;
      end else begin
        @(posedge divffclk); #1;
        start = 1'b0;
        cyc++;
        if (cyc == poke_cyc) begin
          start   = 1'b1;
          E       = 7'd0;
          afh_map = '0;
        end
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, int'(got), 1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_fk"}, int'(fk), exp_fk);
    check({tag, "_remapped"}, int'(remapped), exp_rm);
    check({tag, "_err"}, int'(err), exp_err);
    @(posedge divffclk); #1;
    if (got) begin
      @(negedge divffclk);
      check({tag, "_done_pulse"}, int'(done), 0);
      @(posedge divffclk); #1;
    end
  endtask

  task automatic base_inputs();
    X = '0; A = '0; B = '0; C = '0; D = '0;
    E = 7'd10; F = 7'd20; Fprime = '0;
    Y1 = 1'b0; Y2 = '0;
    afh_map = '1; afh_modN = 7'd79;
  endtask

  initial begin
    int lat, efk, erm, eerr;
    bit saw;
    rstz = 1'b1; start = 1'b0; abort = 1'b0;
    base_inputs();
    #2 rstz = 1'b0;
    #10;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fk", int'(fk), 0);
    check("rst_remapped", int'(remapped), 0);
    check("rst_err", int'(err), 0);
    @(negedge divffclk); rstz = 1'b1;
    @(posedge divffclk); #1;

    run_req("t1_basic", 4, 60, 0, 0, -1);
    E = 7'd70;
    run_req("t2_mod79", 5, 22, 0, 0, -1);
    afh_map[22] = 1'b0; afh_modN = 7'd78; Fprime = 7'd20;
    run_req("t3_remap", 21, 26, 1, 0, -1);
    run_req("t5_start_busy", 21, 26, 1, 0, 12);

    // Abort in SCAN of a request that would have produced channel 28.
    base_inputs();
    E = 7'd70; Fprime = 7'd21; afh_map[22] = 1'b0; afh_modN = 7'd78;
    start = 1'b1;
    @(posedge divffclk); #1;
    start = 1'b0;
    repeat (11) @(posedge divffclk);
    #1 abort = 1'b1;
    @(posedge divffclk); #1;
    abort = 1'b0;
    @(negedge divffclk);
    check("abort_busy", int'(busy), 0);
    saw = 1'b0;
    repeat (30) begin
      @(posedge divffclk); #1;
      if (done) saw = 1'b1;
    end
    check("abort_no_done", int'(saw), 0);
    check("abort_fk_held", int'(fk), 26);
    check("abort_rm_held", int'(remapped), 1);
    check("abort_err_held", int'(err), 0);

    // Reset in the middle of a 4-cycle MOD79 phase.
    base_inputs();
    Y1 = 1'b1; Y2 = 6'd32; E = 7'd127; F = 7'd127;
    start = 1'b1;
    @(posedge divffclk); #1;
    start = 1'b0;
    repeat (2) @(posedge divffclk);
    #1;
    check("mid_busy", int'(busy), 1);
    rstz = 1'b0;
    #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_fk", int'(fk), 0);
    check("mrst_remapped", int'(remapped), 0);
    check("mrst_err", int'(err), 0);
    @(negedge divffclk); rstz = 1'b1;
    @(posedge divffclk); #1;
    base_inputs();
    run_req("t1_after_rst", 4, 60, 0, 0, -1);

    base_inputs();
    afh_map = '0; afh_map[0] = 1'b1; afh_modN = 7'd5;
    E = 7'd1; F = 7'd20; Fprime = 7'd2;
    run_req("t4_exhaust", 84, 0, 0, 1, -1);
    afh_modN = 7'd0;
    run_req("t4_n_zero", 5, 0, 0, 1, -1);

    for (int n = 0; n < 1200; n++) begin
      X = 5'($urandom); A = 5'($urandom); B = 4'($urandom);
      E = 7'($urandom); F = 7'($urandom); Fprime = 7'($urandom);
      if (n < 1000) begin
        Y1 = 1'b1; Y2 = 6'd32; C = '0; D = '0;
      end else begin
        Y1 = 1'($urandom); Y2 = Y1 ? 6'd32 : 6'd0;
        C = 5'($urandom); D = 9'($urandom);
      end
      for (int i = 0; i < NCH; i++) afh_map[7'(i)] = ($urandom_range(7, 0) != 0);
      afh_modN = ($urandom_range(15, 0) == 0) ? 7'($urandom) : 7'($countones(afh_map));
      model(lat, efk, erm, eerr);
      run_req("rnd", lat, efk, erm, eerr, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
